// File: rtl/mem_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter_if
// Purpose  : Bundle of the three cache-miss requester ports and the single
//            backing-memory port that mem_req_arbiter sits between.
//            master = the arbiter, slave = requesters plus memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_req_arbiter_if #(
  parameter int CL_SIZE = 128,
  parameter int ADDR_W  = 32
);
  // Requester side
  logic               req_even, req_odd, req_data;
  logic [ADDR_W-1:0]  addr_even, addr_odd, addr_data;
  logic               is_write_even, is_write_odd, is_write_data;
  logic [CL_SIZE-1:0] wdata_even, wdata_odd, wdata_data;
  logic               resp_even, resp_odd, resp_data;
  logic               err_even, err_odd, err_data;
  logic [CL_SIZE-1:0] rdata_out;

  // Memory side
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_is_write;
  logic [CL_SIZE-1:0] mem_wdata;
  logic               mem_resp_valid;
  logic [CL_SIZE-1:0] mem_rdata;

  logic               busy;

  modport master (
    input  req_even, req_odd, req_data,
    input  addr_even, addr_odd, addr_data,
    input  is_write_even, is_write_odd, is_write_data,
    input  wdata_even, wdata_odd, wdata_data,
    output resp_even, resp_odd, resp_data,
    output err_even, err_odd, err_data,
    output rdata_out,
    output mem_req_valid, mem_addr, mem_is_write, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output busy
  );

  modport slave (
    output req_even, req_odd, req_data,
    output addr_even, addr_odd, addr_data,
    output is_write_even, is_write_odd, is_write_data,
    output wdata_even, wdata_odd, wdata_data,
    input  resp_even, resp_odd, resp_data,
    input  err_even, err_odd, err_data,
    input  rdata_out,
    input  mem_req_valid, mem_addr, mem_is_write, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Purpose  : Round-robin arbiter sharing one backing-memory port between the
//            I$ even bank, I$ odd bank and D$ miss logic. One transaction in
//            flight; a per-transaction timeout completes it with an error.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
  parameter int CL_SIZE = 128,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_req_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ID_EVEN = 2'd0;
  localparam logic [1:0] ID_ODD  = 2'd1;
  localparam logic [1:0] ID_DATA = 2'd2;

  // Counter can run one past TIMEOUT when the handshake lands on the last
  // ISSUE cycle, so size it for TIMEOUT+1.
  localparam int              CNT_W     = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t             state, state_nx;
  logic [1:0]         last, last_nx;
  logic [1:0]         grant, grant_nx;
  logic [1:0]         pick, c0, c1, c2;
  logic [3:0]         reqs;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               timed_out;
  logic               err_nx;
  logic [ADDR_W-1:0]  pick_addr, addr_nx;
  logic               pick_wr, wr_nx;
  logic [CL_SIZE-1:0] pick_wdata, wdata_nx, rdata_nx;

  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == ID_DATA) ? ID_EVEN : id + 2'd1;
  endfunction

  // Rotating priority: the requester right after the last grant looks first.
  always_comb begin
    reqs = {1'b0, bus.req_data, bus.req_odd, bus.req_even};
    c0   = next_id(last);
    c1   = next_id(c0);
    c2   = next_id(c1);
    if (reqs[c0])      pick = c0;
    else if (reqs[c1]) pick = c1;
    else               pick = c2;
  end

  // Payload of the requester that would win this cycle.
  always_comb begin
    pick_addr  = bus.addr_even;
    pick_wr    = bus.is_write_even;
    pick_wdata = bus.wdata_even;
    case (pick)
      ID_ODD: begin
        pick_addr  = bus.addr_odd;
        pick_wr    = bus.is_write_odd;
        pick_wdata = bus.wdata_odd;
      end
      ID_DATA: begin
        pick_addr  = bus.addr_data;
        pick_wr    = bus.is_write_data;
        pick_wdata = bus.wdata_data;
      end
      default: ;
    endcase
  end

  assign timed_out = (cnt >= CNT_LIMIT);

  // Next-state logic; a response beats a timeout landing in the same cycle.
  always_comb begin
    state_nx = state;
    last_nx  = last;
    grant_nx = grant;
    cnt_nx   = cnt;
    addr_nx  = bus.mem_addr;
    wr_nx    = bus.mem_is_write;
    wdata_nx = bus.mem_wdata;
    rdata_nx = bus.rdata_out;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (|reqs) begin
          state_nx = ISSUE;
          grant_nx = pick;
          last_nx  = pick;
          cnt_nx   = '0;
          addr_nx  = pick_addr;
          wr_nx    = pick_wr;
          wdata_nx = pick_wdata;
        end
      end
      ISSUE: begin
        cnt_nx = cnt + 1'b1;
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          state_nx = WAIT;
        end else if (timed_out) begin
          state_nx = DONE;
          err_nx   = 1'b1;
          rdata_nx = '0;
        end
      end
      WAIT: begin
        cnt_nx = cnt + 1'b1;
        if (bus.mem_resp_valid) begin
          state_nx = DONE;
          // A write ack carries no fill data.
          rdata_nx = bus.mem_is_write ? '0 : bus.mem_rdata;
        end else if (timed_out) begin
          state_nx = DONE;
          err_nx   = 1'b1;
          rdata_nx = '0;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register; every output is a flop derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      last              <= ID_DATA;
      grant             <= ID_EVEN;
      cnt               <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_is_write  <= 1'b0;
      bus.mem_wdata     <= '0;
      bus.rdata_out     <= '0;
      bus.busy          <= 1'b0;
      bus.resp_even     <= 1'b0;
      bus.resp_odd      <= 1'b0;
      bus.resp_data     <= 1'b0;
      bus.err_even      <= 1'b0;
      bus.err_odd       <= 1'b0;
      bus.err_data      <= 1'b0;
    end else begin
      state             <= state_nx;
      last              <= last_nx;
      grant             <= grant_nx;
      cnt               <= cnt_nx;
      bus.mem_req_valid <= (state_nx == ISSUE);
      bus.mem_addr      <= addr_nx;
      bus.mem_is_write  <= wr_nx;
      bus.mem_wdata     <= wdata_nx;
      bus.rdata_out     <= rdata_nx;
      bus.busy          <= (state_nx != IDLE);
      bus.resp_even     <= (state_nx == DONE) && (grant_nx == ID_EVEN);
      bus.resp_odd      <= (state_nx == DONE) && (grant_nx == ID_ODD);
      bus.resp_data     <= (state_nx == DONE) && (grant_nx == ID_DATA);
      bus.err_even      <= (state_nx == DONE) && (grant_nx == ID_EVEN) && err_nx;
      bus.err_odd       <= (state_nx == DONE) && (grant_nx == ID_ODD)  && err_nx;
      bus.err_data      <= (state_nx == DONE) && (grant_nx == ID_DATA) && err_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_arbiter
// Purpose  : Self-checking bench for mem_req_arbiter. A transaction-level
//            model predicts the grant (round-robin over the request vector)
//            and the completion cycle/error from the ready/response delays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

  localparam int CL = 128;
  localparam int AW = 32;
  localparam int TA = 20;   // timeout of the main instance
  localparam int TB = 8;    // timeout of the timeout-only instance

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.CL_SIZE(CL), .ADDR_W(AW)) ifa ();
  mem_req_arbiter_if #(.CL_SIZE(CL), .ADDR_W(AW)) ifb ();

  mem_req_arbiter #(.CL_SIZE(CL), .ADDR_W(AW), .TIMEOUT(TA)) u_dut (
    .clk(clk), .rst(rst_a), .bus(ifa)
  );
  mem_req_arbiter #(.CL_SIZE(CL), .ADDR_W(AW), .TIMEOUT(TB)) u_dut_to (
    .clk(clk), .rst(rst_b), .bus(ifb)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [2:0]    req_v;
  logic [AW-1:0] m_addr  [3];
  logic          m_wr    [3];
  logic [CL-1:0] m_wdata [3];
  int            m_last;
  logic [2:0]    persist;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CL-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int rr_pick(input int last, input logic [2:0] r);
    for (int k = 1; k <= 3; k++)
      if (r[(last + k) % 3]) return (last + k) % 3;
    return 0;
  endfunction

  task automatic drive_a();
    ifa.req_even      = req_v[0];
    ifa.req_odd       = req_v[1];
    ifa.req_data      = req_v[2];
    ifa.addr_even     = m_addr[0];
    ifa.addr_odd      = m_addr[1];
    ifa.addr_data     = m_addr[2];
    ifa.is_write_even = m_wr[0];
    ifa.is_write_odd  = m_wr[1];
    ifa.is_write_data = m_wr[2];
    ifa.wdata_even    = m_wdata[0];
    ifa.wdata_odd     = m_wdata[1];
    ifa.wdata_data    = m_wdata[2];
  endtask

  task automatic new_req(input int r);
    req_v[r]   = 1'b1;
    m_addr[r]  = $urandom();
    m_wr[r]    = (r == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    m_wdata[r] = (r == 2) ? rand128() : '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, {ifa.resp_data, ifa.resp_odd, ifa.resp_even, ifa.err_data, ifa.err_odd,
              ifa.err_even, ifa.rdata_out, ifa.mem_req_valid, ifa.mem_addr,
              ifa.mem_is_write, ifa.mem_wdata, ifa.busy}, '0);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    req_v = '0;
    drive_a();
    ifa.mem_req_ready  = 1'b0;
    ifa.mem_resp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset_values");
    rst_a  = 1'b0;
    m_last = 2;
  endtask

  // Runs one transaction from an IDLE-cycle negedge with requests pending.
  // Ready rises rdy_d cycles into ISSUE; the response comes rsp_d cycles
  // after the handshake. Ends at the negedge of the following IDLE cycle.
  task automatic do_txn(input int rdy_d, input int rsp_d, input logic [CL-1:0] rd,
                        input bit drop_early);
    int id, hs, rsp_idx, exp_idx;
    bit terr, issue;
    logic [CL-1:0] exp_rd;
    logic [2:0] oh;
    id      = rr_pick(m_last, req_v);
    m_last  = id;
    hs      = (rdy_d <= TA) ? rdy_d : -1;
    rsp_idx = (hs >= 0) ? hs + 1 + rsp_d : -1;
    if (hs >= 0 && rsp_idx <= TA) begin
      terr    = 1'b0;
      exp_idx = rsp_idx + 1;
      exp_rd  = m_wr[id] ? '0 : rd;
    end else begin
      terr    = 1'b1;
      exp_idx = TA + 1;
      exp_rd  = '0;
    end
    oh = 3'b001 << id;
    for (int idx = 0; idx <= exp_idx + 1; idx++) begin
      issue = (hs >= 0) ? (idx <= hs) : (idx <= TA);
      @(negedge clk);
      chk("req_valid", ifa.mem_req_valid, issue);
      if (issue)
        chk("payload", {ifa.mem_addr, ifa.mem_is_write, ifa.mem_wdata},
            {m_addr[id], m_wr[id], m_wdata[id]});
      chk("resp", {ifa.resp_data, ifa.resp_odd, ifa.resp_even},
          (idx == exp_idx) ? oh : 3'b000);
      chk("err", {ifa.err_data, ifa.err_odd, ifa.err_even},
          (idx == exp_idx && terr) ? oh : 3'b000);
      chk("busy", ifa.busy, idx <= exp_idx);
      if (idx == exp_idx) chk("rdata_out", ifa.rdata_out, exp_rd);
      if (idx == 0) req_v = req_v | persist;
      if (drop_early && idx == 1) req_v[id] = 1'b0;
      if (idx == exp_idx) req_v[id] = 1'b0;
      ifa.mem_req_ready = (idx >= rdy_d);
      ifa.mem_rdata     = rand128();
      if (idx == rsp_idx) begin
        ifa.mem_resp_valid = 1'b1;   // on time, or late after a timeout
        ifa.mem_rdata      = rd;
      end else begin
        // Stray responses only where the arbiter must ignore them.
        ifa.mem_resp_valid = (issue || idx >= exp_idx) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      drive_a();
    end
  endtask

  initial begin
    int rdy, rsp;
    persist = '0;
    for (int r = 0; r < 3; r++) begin
      m_addr[r] = '0; m_wr[r] = 1'b0; m_wdata[r] = '0;
    end
    ifa.mem_rdata = '0;
    rst_b = 1'b1;
    ifb.req_even = 1'b0; ifb.req_odd = 1'b0; ifb.req_data = 1'b0;
    ifb.addr_even = '0; ifb.addr_odd = '0; ifb.addr_data = '0;
    ifb.is_write_even = 1'b0; ifb.is_write_odd = 1'b0; ifb.is_write_data = 1'b0;
    ifb.wdata_even = '0; ifb.wdata_odd = '0; ifb.wdata_data = '0;
    ifb.mem_req_ready = 1'b0; ifb.mem_resp_valid = 1'b0; ifb.mem_rdata = '0;

    // Single read from even
    reset_a();
    m_addr[0] = 32'h20; req_v = 3'b001; drive_a();
    do_txn(0, 2, {4{32'hDEADBEEF}}, 1'b0);

    // Fairness with all three requesters continuously re-requesting
    reset_a();
    m_addr[0] = 32'h20; m_addr[1] = 32'h30; m_addr[2] = 32'hFF000040;
    m_wr[2] = 1'b0; m_wdata[2] = '0;
    req_v = 3'b111; persist = 3'b111; drive_a();
    for (int k = 0; k < 6; k++) do_txn(0, 1, rand128(), 1'b0);
    persist = '0;
    while (req_v != 0) do_txn(0, 0, rand128(), 1'b0);

    // Writeback from D$: fill data must read as zero
    m_addr[2] = 32'h40; m_wr[2] = 1'b1; m_wdata[2] = {16{8'hA5}};
    req_v = 3'b100; drive_a();
    do_txn(1, 1, rand128(), 1'b0);

    // Backpressure: ready held low for 10 cycles
    m_addr[0] = 32'h80; req_v = 3'b001; drive_a();
    do_txn(10, 0, rand128(), 1'b0);

    // Response on the last allowed cycle, one cycle late, and never-ready
    req_v = 3'b010; m_addr[1] = 32'h1000; drive_a();
    do_txn(0, TA - 1, rand128(), 1'b0);
    req_v = 3'b010; drive_a();
    do_txn(0, TA, rand128(), 1'b0);
    req_v = 3'b001; drive_a();
    do_txn(TA + 1, 0, rand128(), 1'b0);

    // Request dropped before its response still completes
    req_v = 3'b100; m_wr[2] = 1'b0; drive_a();
    do_txn(2, 3, rand128(), 1'b1);

    // Reset while in WAIT abandons the transaction; even wins afterwards
    req_v = 3'b010; m_addr[1] = 32'h30; drive_a();
    ifa.mem_req_ready = 1'b1; ifa.mem_resp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_wait", {ifa.busy, ifa.mem_req_valid}, 2'b10);
    rst_a = 1'b1; ifa.mem_resp_valid = 1'b1; ifa.mem_rdata = rand128();
    @(negedge clk);
    check_reset_outputs("mid_reset_1");
    ifa.mem_resp_valid = 1'b0; ifa.mem_req_ready = 1'b0;
    req_v = 3'b111; drive_a();
    @(negedge clk);
    check_reset_outputs("mid_reset_2");
    rst_a = 1'b0; m_last = 2;
    do_txn(0, 1, rand128(), 1'b0);
    while (req_v != 0) do_txn(0, 0, rand128(), 1'b0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      if (req_v == 0 && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        chk("idle", {ifa.busy, ifa.mem_req_valid}, 2'b00);
      end
      for (int r = 0; r < 3; r++)
        if (!req_v[r] && $urandom_range(0, 1) == 1) new_req(r);
      if (req_v == 0) new_req($urandom_range(0, 2));
      drive_a();
      rdy = ($urandom_range(0, 9) == 0) ? ((TA - 1) + 2 * $urandom_range(0, 1))
                                        : $urandom_range(0, 3);
      rsp = ($urandom_range(0, 9) == 0) ? $urandom_range(TA - 4, TA) : $urandom_range(0, 5);
      do_txn(rdy, rsp, rand128(), 1'b0);
    end

    // Timeout instance: memory accepts but never answers in time
    @(negedge clk);
    chk("to_reset", {ifb.resp_odd, ifb.err_odd, ifb.busy, ifb.mem_req_valid}, 4'b0000);
    rst_b = 1'b0;
    ifb.req_odd = 1'b1; ifb.addr_odd = 32'h30; ifb.mem_req_ready = 1'b1;
    for (int idx = 0; idx <= 13; idx++) begin
      @(negedge clk);
      chk("to_resp", {ifb.resp_data, ifb.resp_odd, ifb.resp_even}, (idx == 9) ? 3'b010 : 3'b000);
      chk("to_err", {ifb.err_data, ifb.err_odd, ifb.err_even}, (idx == 9) ? 3'b010 : 3'b000);
      chk("to_busy", ifb.busy, idx <= 9);
      if (idx == 0) chk("to_valid", {ifb.mem_req_valid, ifb.mem_addr}, {1'b1, 32'h30});
      if (idx == 9) begin
        chk("to_rdata", ifb.rdata_out, '0);
        ifb.req_odd = 1'b0;
      end
      ifb.mem_resp_valid = (idx >= 9);   // late responses must be ignored
      ifb.mem_rdata      = rand128();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
